wb_arbiter: RTL

- Shares the single 16-bit register-file write-back port between NREQ producers: ALU, load unit and multiplier.
- Arbitrates round-robin and registers the winning write into wb_v/wb_rd/wb_data, which drive the 16-way write-back demux and register file.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards.

---
 rtl/wb_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 20 ++
 rtl/wb_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the write-back arbiter
package wb_pkg;
  localparam int DW = 16;
  localparam int NREG = 16;
  localparam int AW = $clog2(NREG);
  localparam int CNT_MAX = 3;
  typedef logic [AW-1:0] reg_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting after the last winner
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back port sharing with pending-write scoreboard
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW = wb_pkg::DW,
  parameter int NREG = wb_pkg::NREG,
  parameter int ZERO_R0 = 0,
  localparam int AW = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_v,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 alloc_v,
  input  logic [AW-1:0]        alloc_rd,
  output logic                 alloc_ready,
  output logic [NREG-1:0]      busy,
  output logic                 wb_v,
  output logic [AW-1:0]        wb_rd,
  output logic [DW-1:0]        wb_data
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [IW-1:0] ptr, idx;
  logic accept, fwd, inc, dec;
  logic [AW-1:0] rd;
  logic [DW-1:0] data;
  logic [1:0] cnt [NREG];
  logic [NREG-1:0] up, dn;
  rr_arbiter #(.N(NREQ)) u_rr (.req(req_v), .ptr(ptr), .gnt(req_ready), .idx(idx));
  assign accept = |req_ready;
  assign rd = req_rd[int'(idx)*AW +: AW];
  assign data = req_data[int'(idx)*DW +: DW];
  assign fwd = !(ZERO_R0 != 0 && rd == '0);
  assign alloc_ready = cnt[alloc_rd] != 2'(CNT_MAX);
  assign inc = alloc_v & alloc_ready & !(ZERO_R0 != 0 && alloc_rd == '0);
  assign dec = accept & fwd;
  assign up = inc ? NREG'(1) << alloc_rd : '0;
  assign dn = dec ? NREG'(1) << rd : '0;
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) busy[r] = cnt[r] != 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
      wb_v <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
    end else begin
      wb_v <= accept & fwd;
      if (accept) begin
        ptr <= idx;
        wb_rd <= rd;
        wb_data <= data;
      end
      // a write to an unreserved register leaves its count at zero
      for (int r = 0; r < NREG; r++)
        if (up[r] && !dn[r]) cnt[r] <= cnt[r] + 2'd1;
        else if (dn[r] && !up[r] && cnt[r] != 2'd0) cnt[r] <= cnt[r] - 2'd1;
    end
endmodule
